// File: rtl/demux1_4_buf.sv
// 1-to-4 demultiplexer with a one-word holding register per lane.
// A lane is refilled in the same cycle that its consumer acks, so back-to-back words see no bubble.
module demux1_4_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic [3:0]       ack,
  output logic [7:0]       xfer_cnt
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       sel;
  logic             accept;

  always_comb begin
    sel      = 4'b0001 << s;
    // An ack on the selected lane frees it in time for this cycle's word.
    in_ready = ~valid_q[s] | ack[s];
    accept   = in_valid & in_ready;
    cnt_d    = accept ? cnt_q + 8'd1 : cnt_q;
    for (int n = 0; n < 4; n++) begin
      data_d[n]  = data_q[n];
      valid_d[n] = valid_q[n] & ~ack[n];
      if (accept && sel[n]) begin
        data_d[n]  = a;
        valid_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        data_q[n] <= data_d[n];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o0       = data_q[0];
  assign o1       = data_q[1];
  assign o2       = data_q[2];
  assign o3       = data_q[3];
  assign v0       = valid_q[0];
  assign v1       = valid_q[1];
  assign v2       = valid_q[2];
  assign v3       = valid_q[3];
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: directed scenarios plus randomized traffic
// compared against a lane-level behavioural model.
module tb_demux1_4_buf;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [1:0]   s;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o0, o1, o2, o3;
  logic         v0, v1, v2, v3;
  logic [3:0]   ack;
  logic [7:0]   xfer_cnt;

  logic [W-1:0] dut_o [4];
  logic [3:0]   dut_v;

  logic [W-1:0] m_o [4];
  logic [3:0]   m_v;
  logic [7:0]   m_cnt;

  int checks;
  int errors;

  demux1_4_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .v0       (v0),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .ack      (ack),
    .xfer_cnt (xfer_cnt)
  );

  assign dut_o[0] = o0;
  assign dut_o[1] = o1;
  assign dut_o[2] = o2;
  assign dut_o[3] = o3;
  assign dut_v    = {v3, v2, v1, v0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a falling edge; leaves time for combinational settle.
  task automatic drive(input logic rst, input logic iv, input logic [1:0] ss,
                       input logic [W-1:0] aa, input logic [3:0] ak);
    reset    = rst;
    in_valid = iv;
    s        = ss;
    a        = aa;
    ack      = ak;
    #1;
  endtask

  // Advance the model by the lane rules, then let the DUT take one rising edge.
  task automatic step();
    logic rdy;
    logic took;
    if (reset) begin
      for (int n = 0; n < 4; n++) m_o[n] = '0;
      m_v   = '0;
      m_cnt = '0;
    end else begin
      rdy  = !m_v[s] || ack[s];
      took = in_valid && rdy;
      for (int n = 0; n < 4; n++) begin
        if (took && (int'(s) == n)) begin
          m_o[n] = a;
          m_v[n] = 1'b1;
        end else if (ack[n]) begin
          m_v[n] = 1'b0;
        end
      end
      if (took) m_cnt = m_cnt + 8'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'd2, 16'hbeef, 4'hf);
    step();
    checks++;
    if (dut_v !== 4'b0000 || xfer_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: v=%b cnt=%0d, required v=0000 cnt=0", dut_v, xfer_cnt);
    end
    checks++;
    if ({o3, o2, o1, o0} !== '0) begin
      errors++;
      $display("FAIL reset_data: o=%h, required all zero", {o3, o2, o1, o0});
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b0, 2'(n), 16'h0, 4'h0);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready s=%0d: in_ready=%b, required 1", n, in_ready);
      end
    end
  endtask

  task automatic test_basic_route();
    drive(1'b0, 1'b1, 2'd0, 16'd10, 4'h0);
    step();
    checks++;
    if (o0 !== 16'h000a || dut_v !== 4'b0001 || xfer_cnt !== 8'd1) begin
      errors++;
      $display("FAIL route_lane0: o0=%h v=%b cnt=%0d, required 000a 0001 1", o0, dut_v, xfer_cnt);
    end
    drive(1'b0, 1'b1, 2'd1, 16'd12, 4'h0);
    step();
    checks++;
    if (o1 !== 16'h000c || o0 !== 16'h000a || dut_v !== 4'b0011 || xfer_cnt !== 8'd2) begin
      errors++;
      $display("FAIL route_lane1: o1=%h o0=%h v=%b cnt=%0d, required 000c 000a 0011 2",
               o1, o0, dut_v, xfer_cnt);
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 2'd0, 16'h1234, 4'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle %0d: in_ready=%b, required 0", c, in_ready);
      end
      step();
      checks++;
      if (o0 !== 16'h000a || xfer_cnt !== 8'd2 || dut_v !== 4'b0011) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: o0=%h cnt=%0d v=%b, required 000a 2 0011",
                 c, o0, xfer_cnt, dut_v);
      end
    end
    drive(1'b0, 1'b1, 2'd0, 16'h1234, 4'b0001);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ack_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    checks++;
    if (o0 !== 16'h1234 || v0 !== 1'b1 || xfer_cnt !== 8'd3) begin
      errors++;
      $display("FAIL stall_release: o0=%h v0=%b cnt=%0d, required 1234 1 3", o0, v0, xfer_cnt);
    end
  endtask

  task automatic test_release();
    logic [W-1:0] word;
    word = W'($urandom);
    drive(1'b0, 1'b1, 2'd2, word, 4'h0);
    step();
    drive(1'b0, 1'b0, 2'd2, 16'h0, 4'b0100);
    step();
    checks++;
    if (v2 !== 1'b0 || o2 !== word || dut_v !== 4'b0011) begin
      errors++;
      $display("FAIL release_lane2: v2=%b o2=%h v=%b, required 0 %h 0011", v2, o2, dut_v, word);
    end
    drive(1'b0, 1'b0, 2'd3, 16'h0, 4'b1000);
    step();
    checks++;
    if (dut_v !== 4'b0011 || o3 !== 16'h0 || xfer_cnt !== 8'd4) begin
      errors++;
      $display("FAIL ack_empty_lane3: v=%b o3=%h cnt=%0d, required 0011 0000 4",
               dut_v, o3, xfer_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), W'($urandom), 4'($urandom & $urandom));
      checks++;
      if (!reset && in_ready !== (!m_v[s] || ack[s])) begin
        errors++;
        $display("FAIL rand_ready iter %0d: in_ready=%b, required %b", i, in_ready,
                 (!m_v[s] || ack[s]));
      end
      step();
      checks++;
      if (dut_v !== m_v || xfer_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_state iter %0d: v=%b cnt=%0d, required v=%b cnt=%0d",
                 i, dut_v, xfer_cnt, m_v, m_cnt);
      end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (dut_o[n] !== m_o[n]) begin
          errors++;
          $display("FAIL rand_data iter %0d lane %0d: o=%h, required %h", i, n, dut_o[n], m_o[n]);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    drive(1'b1, 1'b0, 2'd0, 16'h0, 4'h0);
    step();
    // All acks held high keep every lane ready, so each cycle is an acceptance.
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 2'($urandom_range(0, 3)), W'($urandom), 4'hf);
      step();
    end
    checks++;
    if (xfer_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count: cnt=%0d, required 0", xfer_cnt);
    end
    drive(1'b0, 1'b0, 2'd0, 16'h0, 4'hf);
    step();
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b1, 2'(n), W'(16'h1111 * (n + 1)), 4'h0);
      step();
    end
    checks++;
    if (dut_v !== 4'b1111 || xfer_cnt !== 8'd4 || o2 !== 16'h3333) begin
      errors++;
      $display("FAIL fill_all: v=%b cnt=%0d o2=%h, required 1111 4 3333", dut_v, xfer_cnt, o2);
    end
    drive(1'b1, 1'b1, 2'd1, 16'hffff, 4'hf);
    step();
    checks++;
    if (dut_v !== 4'b0000 || xfer_cnt !== 8'd0 || {o3, o2, o1, o0} !== '0) begin
      errors++;
      $display("FAIL reset_full: v=%b cnt=%0d o=%h, required 0000 0 all zero",
               dut_v, xfer_cnt, {o3, o2, o1, o0});
    end
    drive(1'b0, 1'b0, 2'd0, 16'h0, 4'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int n = 0; n < 4; n++) m_o[n] = '0;
    m_v   = '0;
    m_cnt = '0;
    reset = 1'b1;
    in_valid = 1'b0;
    s   = 2'd0;
    a   = '0;
    ack = 4'h0;
    @(negedge clk);
    test_reset();
    test_basic_route();
    test_stall();
    test_release();
    test_random();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1_4_buf.md
DEMUX1_4_BUF -- requirements
Module: demux1_4_buf

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of input a and outputs o0..o3.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port a, input, WIDTH bits, SHALL carry the data word to distribute.
REQ-005 Port s, input, 2 bits, SHALL select the destination lane (0..3).
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that a and s are valid.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the selected lane can accept a word this cycle.
REQ-008 Ports o0..o3, output, WIDTH bits each, SHALL be the per-lane holding registers.
REQ-009 Ports v0..v3, output, 1 bit each, SHALL flag that the corresponding oN holds an unconsumed word.
REQ-010 Port ack, input, 4 bits, SHALL let the consumer on lane N release that lane via ack[N].
REQ-011 Port xfer_cnt, output, 8 bits, SHALL count accepted transfers.

Function
REQ-012 Each lane SHALL have two states, EMPTY (vN=0) and FULL (vN=1).
REQ-013 in_ready SHALL be combinational: in_ready = !v[s] | ack[s].
REQ-014 A transfer SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; nothing else SHALL count as acceptance.
REQ-015 On acceptance: o[s] <= a, v[s] <= 1, and xfer_cnt <= xfer_cnt+1; latency SHALL be one cycle (data visible on o[s] and v[s] high in the next cycle).
REQ-016 Lanes not selected by s SHALL NOT change, except through their own ack bit.
REQ-017 If ack[N]=1 and vN=1 with no acceptance into lane N, then vN <= 0 (FULL->EMPTY).
REQ-018 If ack[N]=1 and a transfer into lane N is accepted in the same cycle, oN SHALL take the new word and vN SHALL stay 1 (back-to-back, no bubble).
REQ-019 ack[N]=1 while vN=0 SHALL be ignored and SHALL NOT affect in_ready, except as the formula in REQ-013 allows.
REQ-020 oN SHALL hold its last value after release; only vN qualifies the data.
REQ-021 in_valid=1 with in_ready=0 SHALL be a stall: no state change. s and a MAY change during a stall, and readiness SHALL be re-evaluated each cycle for the current s.
REQ-022 xfer_cnt SHALL wrap from 255 to 0 with no flag.
REQ-023 Multiple ack bits SHALL be honoured independently in the same cycle.

Reset
REQ-024 While reset=1 at a rising edge: o0..o3 <= 0, v0..v3 <= 0, and xfer_cnt <= 0. in_valid and ack SHALL be ignored.
REQ-025 Reset during a stall or with lanes FULL SHALL discard all held words; no acceptance SHALL occur in the reset cycle.
REQ-026 After reset deasserts, in_ready SHALL be 1 for any s while no ack is pending, since all lanes are EMPTY.

Verification
REQ-027 Basic route: reset; a=10, s=0, in_valid=1 for 1 cycle -> next cycle o0=16'h000a, v0=1, v1..v3=0, xfer_cnt=1.
REQ-028 Second lane: then a=12, s=1, in_valid=1 -> o1=16'h000c, v1=1, o0 still 16'h000a, xfer_cnt=2.
REQ-029 Stall: lane 0 FULL, ack=0; a=16'h1234, s=0, in_valid=1 for 3 cycles -> in_ready=0 throughout, o0 unchanged, xfer_cnt unchanged; then ack[0]=1 -> accepted, o0=16'h1234, v0=1.
REQ-030 Release: lane 2 FULL, ack=4'b0100, in_valid=0 -> v2=0 next cycle, o2 retains its value; ack[3]=1 with v3=0 -> no change.
REQ-031 Wrap and reset: 256 accepted transfers from reset -> xfer_cnt=0; assert reset with all lanes FULL and in_valid=1 -> all vN=0, all oN=0, xfer_cnt=0.
